instruction_controller: RTL and testbench
=========================================

# instruction_controller

Multi-cycle control unit for the 16-bit Tron CPU. It sits directly upstream of the datapath, driving every control input the datapath consumes. It fetches each instruction word from unified memory into an internal instruction register and decodes it. It then sequences the datapath through execute, load/store or branch cycles, firing exactly one PC-update strobe per instruction.

## Interface
- WIDTH, 16, instruction/data word width
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- memData  in  16  memory read data; valid one cycle after address presented
- instructionOp  out  8  {IR[15:12], IR[7:4]} (opcode, op-extension)
- immediate  out  16  extended immediate (rules below)
- regAddA  out  4  IR[3:0] (Rsrc / jump target / memory address register)
- regAddB  out  4  IR[11:8] (Rdest; also register-file write address)
- ALUOp  out  4  ADD 0000, SUB 0001, CMP 0010, AND 0011, OR 0100, XOR 0101, MOV 0110
- shiftOp  out  2  00 logical shift by register amount, 01 logical shift by immediate amount
- busOp  out  3  0 immediate, 1 memory, 2 ALU, 3 shifter, 4 PC
- immMUX  out  1  1 selects immediate as the second operand, 0 selects regA
- regWrite, memWrite, flagWrite  out  1 each  write strobes
- flagOp  out  4  branch condition IR[11:8]
- pcAdd, pcJump, pcBranch  out  1 each  PC-update strobes, mutually exclusive
- addrSel  out  1  memory-address mux: 0 PC, 1 regA

## Operation
- States: FETCH, LATCH, EXEC, LOAD_ADDR, LOAD_WB, STORE, JAL_INC, JAL_WB, BRANCH.
- FETCH: addrSel=0, no strobes. Next state is LATCH.
- LATCH: IR <= memData. Next state is chosen by decode of memData:
  - Opcode 0000, op-ext in {0101,1001,1011,0001,0010,0011,1101}: go to EXEC as ADD/SUB/CMP/AND/OR/XOR/MOV.
  - Opcodes 0101,1001,1011,0001,0010,0011,1101,1111: go to EXEC as the matching immediate ops. 1111 is LUI.
  - Opcode 1000: go to EXEC as a shift. Ext 0100 is LSH (register amount); ext 000x is LSHI.
  - Opcode 0100: ext 0000 goes to LOAD_ADDR; ext 0100 to STORE; ext 1000 to JAL_INC; ext 1100 to BRANCH (Jcond).
  - Opcode 1100: go to BRANCH (Bcond).
  - Any other encoding goes to EXEC as a NOP: pcAdd only, no writes.
- EXEC:
  - immMUX=1 for immediate forms.
  - busOp=2 for ALU ops, 3 for shifts, 0 for MOVI/LUI.
  - regWrite=1 except for CMP/CMPI/NOP.
  - flagWrite=1 for ADD/SUB/CMP and their immediate forms.
  - pcAdd=1. Next state is FETCH.
- LOAD_ADDR: addrSel=1. Next state is LOAD_WB.
- LOAD_WB: addrSel=1, busOp=1, regWrite=1, pcAdd=1. Next state is FETCH.
- STORE: addrSel=1, memWrite=1, pcAdd=1. Store data is regB (Rdest). Next state is FETCH.
- JAL_INC: pcAdd=1. Next state is JAL_WB.
- JAL_WB: busOp=4, regWrite=1, pcJump=1. The incremented PC is linked into Rdest and the jump goes to regA. Next state is FETCH.
- BRANCH: flagOp=IR[11:8]. Bcond asserts pcBranch=1; Jcond asserts pcJump=1. The ProgramCounter evaluates the condition. Next state is FETCH.
- Immediate extension:
  - Sign-extend IR[7:0] by default.
  - ANDI/ORI/XORI zero-extend.
  - LUI gives {IR[7:0],8'h00}.
  - LSHI gives {12'h000, IR[3:0]}.
  - Bcond gives the sign-extended displacement.
- Outputs not listed for a state are 0. Decode fields always reflect the IR.

## Timing
- Reset (async, reset=0):
  - State becomes FETCH and IR becomes 16'h0000.
  - All strobes and addrSel go low; busOp, ALUOp, shiftOp and immMUX go to 0.
  - Takes effect immediately, mid-instruction included. A partially executed load/store/JAL leaves no write.
- First FETCH starts on the first rising edge after reset deasserts.
- Latency in cycles, FETCH inclusive:
  - ALU/shift/imm/NOP: 3.
  - Load: 4.
  - Store: 3.
  - Bcond/Jcond: 3.
  - JAL: 4.
- Strobes are Moore outputs of the registered state and are glitch-free at the datapath. Writes commit on the clock edge ending that state.
- Exactly one of pcAdd/pcJump/pcBranch fires per instruction, always in the final state. JAL fires pcAdd in JAL_INC, then pcJump in JAL_WB.
- JAL with Rdest==Rsrc: the jump uses the old register value (combinational read). The link write and the jump commit on the same edge.
- CMP writes flags only. A following Bcond sees the updated flags because it is at least 2 cycles later.

## Test plan
- Reset during LOAD_WB (reset low mid-cycle) -> outputs drop to 0 asynchronously; regWrite never completes; after release the controller is in FETCH with IR=0000.
- ADDI R3,#-2 (16'h53FE) -> LATCH then EXEC; immediate=16'hFFFE, immMUX=1, ALUOp=0000, busOp=2, regWrite=1, flagWrite=1, pcAdd=1; back in FETCH on cycle 4.
- ANDI R1,#0x80 (16'h1180) -> immediate=16'h0080 (zero-extended); LUI R2,#0x12 (16'hF212) -> immediate=16'h1200, busOp=0.
- LOAD R4,[R7] (16'h4407) -> LOAD_ADDR then LOAD_WB with addrSel=1; busOp=1, regWrite=1, regAddB=4, regAddA=7; 4 cycles total; STORE (16'h4447) -> memWrite for exactly 1 cycle.
- JAL R5,R5 (16'h4585) -> pcAdd in JAL_INC; in JAL_WB busOp=4, regWrite=1, pcJump=1 in the same cycle; no pcBranch.
- Bcond EQ disp -3 (16'hC0FD) -> BRANCH with pcBranch=1, flagOp=0000, immediate=16'hFFFD; illegal word 16'h0000 -> NOP, pcAdd only, no writes.

Source files
------------

// File: rtl/instruction_controller.sv
// Multi-cycle control unit for the 16-bit Tron CPU: fetches into an internal IR,
// decodes it and sequences the datapath with Moore-style control strobes.
module instruction_controller #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] memData,
    output logic [7:0]       instructionOp,
    output logic [WIDTH-1:0] immediate,
    output logic [3:0]       regAddA,
    output logic [3:0]       regAddB,
    output logic [3:0]       ALUOp,
    output logic [1:0]       shiftOp,
    output logic [2:0]       busOp,
    output logic             immMUX,
    output logic             regWrite,
    output logic             memWrite,
    output logic             flagWrite,
    output logic [3:0]       flagOp,
    output logic             pcAdd,
    output logic             pcJump,
    output logic             pcBranch,
    output logic             addrSel
);

    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_LATCH     = 4'd1;
    localparam logic [3:0] S_EXEC      = 4'd2;
    localparam logic [3:0] S_LOAD_ADDR = 4'd3;
    localparam logic [3:0] S_LOAD_WB   = 4'd4;
    localparam logic [3:0] S_STORE     = 4'd5;
    localparam logic [3:0] S_JAL_INC   = 4'd6;
    localparam logic [3:0] S_JAL_WB    = 4'd7;
    localparam logic [3:0] S_BRANCH    = 4'd8;

    localparam logic [3:0] C_NOP   = 4'd0;
    localparam logic [3:0] C_ALU   = 4'd1;
    localparam logic [3:0] C_ALUI  = 4'd2;
    localparam logic [3:0] C_MOVI  = 4'd3;
    localparam logic [3:0] C_LUI   = 4'd4;
    localparam logic [3:0] C_LSH   = 4'd5;
    localparam logic [3:0] C_LSHI  = 4'd6;
    localparam logic [3:0] C_LOAD  = 4'd7;
    localparam logic [3:0] C_STORE = 4'd8;
    localparam logic [3:0] C_JAL   = 4'd9;
    localparam logic [3:0] C_JCOND = 4'd10;
    localparam logic [3:0] C_BCOND = 4'd11;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_CMP = 4'b0010;
    localparam logic [3:0] ALU_AND = 4'b0011;
    localparam logic [3:0] ALU_OR  = 4'b0100;
    localparam logic [3:0] ALU_XOR = 4'b0101;
    localparam logic [3:0] ALU_MOV = 4'b0110;

    localparam logic [2:0] BUS_IMM   = 3'd0;
    localparam logic [2:0] BUS_MEM   = 3'd1;
    localparam logic [2:0] BUS_ALU   = 3'd2;
    localparam logic [2:0] BUS_SHIFT = 3'd3;
    localparam logic [2:0] BUS_PC    = 3'd4;

    // Same 4-bit code names the ALU operation in op-ext (register form) or opcode (immediate form).
    // Bit 4 flags a recognised code.
    function automatic logic [4:0] f_alu_code(input logic [3:0] code);
        case (code)
            4'b0101: f_alu_code = {1'b1, ALU_ADD};
            4'b1001: f_alu_code = {1'b1, ALU_SUB};
            4'b1011: f_alu_code = {1'b1, ALU_CMP};
            4'b0001: f_alu_code = {1'b1, ALU_AND};
            4'b0010: f_alu_code = {1'b1, ALU_OR};
            4'b0011: f_alu_code = {1'b1, ALU_XOR};
            4'b1101: f_alu_code = {1'b1, ALU_MOV};
            default: f_alu_code = {1'b0, ALU_ADD};
        endcase
    endfunction

    function automatic logic [3:0] f_class(input logic [3:0] op, input logic [3:0] ext);
        logic [4:0] alu;
        alu     = f_alu_code((op == 4'b0000) ? ext : op);
        f_class = C_NOP;
        case (op)
            4'b0000: if (alu[4]) f_class = C_ALU;
            4'b0100: begin
                case (ext)
                    4'b0000: f_class = C_LOAD;
                    4'b0100: f_class = C_STORE;
                    4'b1000: f_class = C_JAL;
                    4'b1100: f_class = C_JCOND;
                    default: f_class = C_NOP;
                endcase
            end
            4'b1000: begin
                if (ext == 4'b0100)
                    f_class = C_LSH;
                else if (ext[3:1] == 3'b000)
                    f_class = C_LSHI;
            end
            4'b1100: f_class = C_BCOND;
            4'b1111: f_class = C_LUI;
            default: if (alu[4]) f_class = (op == 4'b1101) ? C_MOVI : C_ALUI;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] f_imm(input logic [3:0] cls, input logic [3:0] op,
                                               input logic [7:0] lo8);
        case (cls)
            C_LUI:  f_imm = {lo8, {(WIDTH-8){1'b0}}};
            C_LSHI: f_imm = {{(WIDTH-4){1'b0}}, lo8[3:0]};
            C_ALUI: begin
                if (op == 4'b0001 || op == 4'b0010 || op == 4'b0011)
                    f_imm = {{(WIDTH-8){1'b0}}, lo8};
                else
                    f_imm = {{(WIDTH-8){lo8[7]}}, lo8};
            end
            default: f_imm = {{(WIDTH-8){lo8[7]}}, lo8};
        endcase
    endfunction

    logic [3:0]       r_state;
    logic [WIDTH-1:0] r_ir;
    logic [3:0]       w_next;
    logic [3:0]       w_cls_ir;
    logic [3:0]       w_cls_mem;
    logic [4:0]       w_alu_ir;

    assign w_cls_ir  = f_class(r_ir[15:12], r_ir[7:4]);
    assign w_cls_mem = f_class(memData[15:12], memData[7:4]);
    assign w_alu_ir  = f_alu_code((r_ir[15:12] == 4'b0000) ? r_ir[7:4] : r_ir[15:12]);

    assign instructionOp = {r_ir[15:12], r_ir[7:4]};
    assign regAddA       = r_ir[3:0];
    assign regAddB       = r_ir[11:8];
    assign immediate     = f_imm(w_cls_ir, r_ir[15:12], r_ir[7:0]);

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH: w_next = S_LATCH;
            S_LATCH: begin
                case (w_cls_mem)
                    C_LOAD:           w_next = S_LOAD_ADDR;
                    C_STORE:          w_next = S_STORE;
                    C_JAL:            w_next = S_JAL_INC;
                    C_JCOND, C_BCOND: w_next = S_BRANCH;
                    default:          w_next = S_EXEC;
                endcase
            end
            S_LOAD_ADDR: w_next = S_LOAD_WB;
            S_JAL_INC:   w_next = S_JAL_WB;
            default:     w_next = S_FETCH;
        endcase
    end

    // IR only loads in LATCH, when memory returns the word addressed during FETCH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
            r_ir    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_LATCH)
                r_ir <= memData;
        end
    end

    always_comb begin
        ALUOp     = ALU_ADD;
        shiftOp   = 2'b00;
        busOp     = BUS_IMM;
        immMUX    = 1'b0;
        regWrite  = 1'b0;
        memWrite  = 1'b0;
        flagWrite = 1'b0;
        flagOp    = 4'b0000;
        pcAdd     = 1'b0;
        pcJump    = 1'b0;
        pcBranch  = 1'b0;
        addrSel   = 1'b0;
        case (r_state)
            S_EXEC: begin
                pcAdd = 1'b1;
                case (w_cls_ir)
                    C_ALU, C_ALUI: begin
                        ALUOp     = w_alu_ir[3:0];
                        busOp     = BUS_ALU;
                        immMUX    = (w_cls_ir == C_ALUI);
                        regWrite  = (w_alu_ir[3:0] != ALU_CMP);
                        flagWrite = (w_alu_ir[3:0] == ALU_ADD) || (w_alu_ir[3:0] == ALU_SUB) ||
                                    (w_alu_ir[3:0] == ALU_CMP);
                    end
                    C_MOVI: begin
                        ALUOp    = ALU_MOV;
                        busOp    = BUS_IMM;
                        immMUX   = 1'b1;
                        regWrite = 1'b1;
                    end
                    C_LUI: begin
                        busOp    = BUS_IMM;
                        immMUX   = 1'b1;
                        regWrite = 1'b1;
                    end
                    C_LSH: begin
                        busOp    = BUS_SHIFT;
                        shiftOp  = 2'b00;
                        regWrite = 1'b1;
                    end
                    C_LSHI: begin
                        busOp    = BUS_SHIFT;
                        shiftOp  = 2'b01;
                        immMUX   = 1'b1;
                        regWrite = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_LOAD_ADDR: addrSel = 1'b1;
            S_LOAD_WB: begin
                addrSel  = 1'b1;
                busOp    = BUS_MEM;
                regWrite = 1'b1;
                pcAdd    = 1'b1;
            end
            S_STORE: begin
                addrSel  = 1'b1;
                memWrite = 1'b1;
                pcAdd    = 1'b1;
            end
            S_JAL_INC: pcAdd = 1'b1;
            // Link write and jump share this edge, so the jump target is the pre-write regA.
            S_JAL_WB: begin
                busOp    = BUS_PC;
                regWrite = 1'b1;
                pcJump   = 1'b1;
            end
            S_BRANCH: begin
                flagOp   = r_ir[11:8];
                pcBranch = (w_cls_ir == C_BCOND);
                pcJump   = (w_cls_ir == C_JCOND);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_instruction_controller.sv
// Bench for instruction_controller: directed programme then random instruction stream,
// checked every cycle against a table-driven model of the instruction set.
module tb_instruction_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [15:0] memData;
    logic [7:0]  instructionOp;
    logic [15:0] immediate;
    logic [3:0]  regAddA, regAddB, ALUOp, flagOp;
    logic [1:0]  shiftOp;
    logic [2:0]  busOp;
    logic        immMUX, regWrite, memWrite, flagWrite, pcAdd, pcJump, pcBranch, addrSel;

    instruction_controller #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .memData(memData),
        .instructionOp(instructionOp), .immediate(immediate),
        .regAddA(regAddA), .regAddB(regAddB), .ALUOp(ALUOp), .shiftOp(shiftOp),
        .busOp(busOp), .immMUX(immMUX), .regWrite(regWrite), .memWrite(memWrite),
        .flagWrite(flagWrite), .flagOp(flagOp), .pcAdd(pcAdd), .pcJump(pcJump),
        .pcBranch(pcBranch), .addrSel(addrSel)
    );

    typedef struct packed {
        logic [7:0]  iop;
        logic [15:0] imm;
        logic [3:0]  ra, rb, alu;
        logic [1:0]  sh;
        logic [2:0]  bus;
        logic        immmux, rw, mw, fw;
        logic [3:0]  fop;
        logic        pa, pj, pb, as;
    } ctl_t;

    ctl_t dut_v;
    assign dut_v = {instructionOp, immediate, regAddA, regAddB, ALUOp, shiftOp, busOp,
                    immMUX, regWrite, memWrite, flagWrite, flagOp, pcAdd, pcJump, pcBranch, addrSel};

    // Position in this table is the ALUOp value; entry is the encoding in opcode/op-ext.
    localparam logic [3:0] CODE_TAB [7] = '{4'b0101, 4'b1001, 4'b1011, 4'b0001,
                                            4'b0010, 4'b0011, 4'b1101};
    localparam int K_NOP = 0, K_ALUR = 1, K_ALUI = 2, K_LUI = 3, K_LSH = 4, K_LSHI = 5,
                   K_LOAD = 6, K_STORE = 7, K_JAL = 8, K_JC = 9, K_BC = 10;

    int n_cmp = 0;
    int n_bad = 0;
    int ph;
    logic [15:0] mir;
    logic [15:0] prog[$];

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic int alu_idx(input logic [3:0] c);
        for (int i = 0; i < 7; i++)
            if (CODE_TAB[i] == c) return i;
        return -1;
    endfunction

    function automatic void classify(input logic [15:0] w, output int k, output int ai);
        logic [3:0] op, ex;
        op = w[15:12];
        ex = w[7:4];
        ai = -1;
        k  = K_NOP;
        if (op == 4'h0) begin
            ai = alu_idx(ex);
            if (ai >= 0) k = K_ALUR;
        end else if (op == 4'hF) k = K_LUI;
        else if (op == 4'h8) begin
            if (ex == 4'h4) k = K_LSH;
            else if (ex == 4'h0 || ex == 4'h1) k = K_LSHI;
        end else if (op == 4'h4) begin
            if (ex == 4'h0) k = K_LOAD;
            else if (ex == 4'h4) k = K_STORE;
            else if (ex == 4'h8) k = K_JAL;
            else if (ex == 4'hC) k = K_JC;
        end else if (op == 4'hC) k = K_BC;
        else begin
            ai = alu_idx(op);
            if (ai >= 0) k = K_ALUI;
        end
    endfunction

    function automatic int post_cycles(input logic [15:0] w);
        int k, ai;
        classify(w, k, ai);
        return (k == K_LOAD || k == K_JAL) ? 2 : 1;
    endfunction

    // ph: 0 FETCH, 1 LATCH, 2.. the instruction's own cycles.
    function automatic ctl_t expect_ctl(input int p, input logic [15:0] w);
        ctl_t e;
        int k, ai, s;
        logic signed [7:0] b;
        classify(w, k, ai);
        b = w[7:0];
        e = '0;
        e.iop = {w[15:12], w[7:4]};
        e.ra  = w[3:0];
        e.rb  = w[11:8];
        e.imm = 16'(int'(b));
        if (k == K_ALUI && ai >= 3 && ai <= 5) e.imm = {8'h00, w[7:0]};
        if (k == K_LUI)  e.imm = 16'(int'(w[7:0]) * 256);
        if (k == K_LSHI) e.imm = {12'h000, w[3:0]};
        s = p - 1;
        if (p >= 2) begin
            case (k)
                K_ALUR, K_ALUI: begin
                    e.alu = 4'(ai);
                    e.bus = (k == K_ALUI && ai == 6) ? 3'd0 : 3'd2;
                    e.immmux = (k == K_ALUI);
                    e.rw = (ai != 2);
                    e.fw = (ai <= 2);
                    e.pa = 1'b1;
                end
                K_LUI:  begin e.immmux = 1'b1; e.rw = 1'b1; e.pa = 1'b1; end
                K_LSH:  begin e.bus = 3'd3; e.rw = 1'b1; e.pa = 1'b1; end
                K_LSHI: begin e.bus = 3'd3; e.sh = 2'b01; e.immmux = 1'b1; e.rw = 1'b1; e.pa = 1'b1; end
                K_LOAD: begin
                    e.as = 1'b1;
                    if (s == 2) begin e.bus = 3'd1; e.rw = 1'b1; e.pa = 1'b1; end
                end
                K_STORE: begin e.as = 1'b1; e.mw = 1'b1; e.pa = 1'b1; end
                K_JAL: begin
                    if (s == 1) e.pa = 1'b1;
                    else begin e.bus = 3'd4; e.rw = 1'b1; e.pj = 1'b1; end
                end
                K_JC:   begin e.fop = w[11:8]; e.pj = 1'b1; end
                K_BC:   begin e.fop = w[11:8]; e.pb = 1'b1; end
                default: e.pa = 1'b1;
            endcase
        end
        return e;
    endfunction

    function automatic logic [15:0] rand_instr();
        logic [15:0] w;
        w = 16'($urandom);
        case ($urandom_range(0, 5))
            0: begin w[15:12] = 4'h0; w[7:4] = CODE_TAB[$urandom_range(0, 6)]; end
            1: begin w[15:12] = 4'h4; w[5:4] = 2'b00; end
            2: begin w[15:12] = 4'h8; w[7:5] = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'b010; end
            3: w[15:12] = CODE_TAB[$urandom_range(0, 6)];
            4: w[15:12] = ($urandom_range(0, 1) == 0) ? 4'hF : 4'hC;
            default: ;
        endcase
        return w;
    endfunction

    task automatic pin_checks();
        if (ph == 2 && mir == 16'h53FE) begin
            cmp("addi_imm", 64'(immediate), 64'h FFFE);
            cmp("addi_ctl", 64'({immMUX, ALUOp, busOp, regWrite, flagWrite, pcAdd}),
                64'({1'b1, 4'h0, 3'd2, 1'b1, 1'b1, 1'b1}));
        end
        if (ph == 2 && mir == 16'h1180) cmp("andi_imm", 64'(immediate), 64'h0080);
        if (ph == 2 && mir == 16'hF212)
            cmp("lui_imm_bus", 64'({immediate, busOp}), 64'({16'h1200, 3'd0}));
        if (ph == 3 && mir == 16'h4407)
            cmp("load_wb", 64'({addrSel, busOp, regWrite, regAddB, regAddA}),
                64'({1'b1, 3'd1, 1'b1, 4'd4, 4'd7}));
        if (ph == 2 && mir == 16'h4447) cmp("store_mw", 64'({memWrite, addrSel}), 64'b11);
        if (ph == 3 && mir == 16'h4585)
            cmp("jal_wb", 64'({busOp, regWrite, pcJump, pcBranch, pcAdd}), 64'({3'd4, 4'b1100}));
        if (ph == 2 && mir == 16'hC0FD)
            cmp("bcond", 64'({pcBranch, flagOp, immediate}), 64'({1'b1, 4'h0, 16'hFFFD}));
        if (ph == 2 && mir == 16'h0000)
            cmp("nop", 64'({pcAdd, regWrite, memWrite, flagWrite}), 64'b1000);
    endtask

    initial begin
        bit rst_done;
        int cyc;
        rst_done = 1'b0;
        cyc = 0;
        reset = 1'b0;
        memData = 16'h0000;
        prog = '{16'h53FE, 16'h1180, 16'hF212, 16'h4407, 16'h4447, 16'h4585, 16'hC0FD, 16'h0000};
        repeat (2) @(negedge clk);
        cmp("reset_state", 64'(dut_v), 64'd0);
        reset = 1'b1;
        ph = 0;
        mir = 16'h0000;
        while (cyc < 4000) begin
            cyc++;
            cmp($sformatf("ctl ph%0d ir=%h", ph, mir), 64'(dut_v), 64'(expect_ctl(ph, mir)));
            pin_checks();
            if ((!rst_done && ph == 3 && mir == 16'h4407) ||
                (prog.size() == 0 && $urandom_range(0, 299) == 0)) begin
                rst_done = 1'b1;
                reset = 1'b0;
                #1;
                cmp("async_reset_outputs", 64'(dut_v), 64'd0);
                @(posedge clk);
                #1;
                cmp("reset_hold_outputs", 64'(dut_v), 64'd0);
                @(negedge clk);
                reset = 1'b1;
                ph = 0;
                mir = 16'h0000;
                continue;
            end
            if (ph == 1)
                memData = (prog.size() != 0) ? prog.pop_front() : rand_instr();
            else
                memData = 16'($urandom);
            @(posedge clk);
            if (ph == 0) ph = 1;
            else if (ph == 1) begin
                mir = memData;
                ph = 2;
            end else if (ph - 1 >= post_cycles(mir)) ph = 0;
            else ph++;
            @(negedge clk);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
